// File: rtl/calc_pkg.sv
// Shared types and constants for the RPN stack calculator core.
// Opcode and state encodings are used by both the core and its bench.
package calc_pkg;

    localparam int DEC_BASE = 10;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_NEG  = 3'd3,
        OP_DUP  = 3'd4,
        OP_SWAP = 3'd5,
        OP_DROP = 3'd6,
        OP_CLR  = 3'd7
    } opcode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_mult.sv
// Signed shift-add multiplier: one multiplier bit per cycle, the MSB weighted negatively.
// done and the full product are valid together in the WIDTH-th cycle after start.
module seq_mult #(
    parameter int WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic signed [2*WIDTH-1:0] mcand;
    logic signed [2*WIDTH-1:0] acc;
    logic signed [2*WIDTH-1:0] shifted;
    logic signed [2*WIDTH-1:0] term;
    logic signed [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]          mplier;
    logic [CNT_W-1:0]          cnt;
    logic                      busy;

    // The sign bit of a two's-complement multiplier carries weight -2^(WIDTH-1).
    always_comb begin
        shifted = mcand <<< cnt;
        term    = '0;
        if (mplier[cnt]) begin
            term = (cnt == LAST) ? -shifted : shifted;
        end
    end

    assign sum     = acc + term;
    assign product = sum;
    assign done    = busy && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc <= sum;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack_calc_core.sv
// RPN operand stack, decimal entry register and multi-cycle ALU for the calculator datapath.
// Define CALC_SAT_EN to saturate overflowing results instead of wrapping them.
module stack_calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH   = 9,
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    input  logic               enter,
    input  logic               op_valid,
    input  logic [2:0]         opcode,
    output logic               ready,
    output logic               result_valid,
    output logic [WIDTH-1:0]   disp,
    output logic               sign,
    output logic               o_flag,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int ENT_W = WIDTH + 4;
    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ENT_W-1:0] ENTRY_MAX = ENT_W'(MAX_POS);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   stk [DEPTH];
    logic [WIDTH-1:0]   stk_nxt [DEPTH];
    logic [DEPTH_W-1:0] depth_nxt;
    logic [WIDTH-1:0]   entry, entry_nxt;
    logic               entry_active, entry_active_nxt;
    logic               o_flag_nxt, err_nxt, result_valid_nxt;

    opcode_t            op;
    logic [IDX_W-1:0]   top_idx, sec_idx, push_idx;
    logic [WIDTH-1:0]   a_val, b_val;
    logic [WIDTH-1:0]   alu_wrap, alu_res;
    logic               alu_ovf;
    logic [ENT_W-1:0]   entry_calc;

    logic                 mul_start, mul_done, mul_ovf;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH-1:0]     mul_res;

`ifdef CALC_SAT_EN
    function automatic logic [WIDTH-1:0] limit(input logic ovf, input logic neg,
                                               input logic [WIDTH-1:0] wrapped);
        if (ovf) return neg ? MIN_NEG : MAX_POS;
        return wrapped;
    endfunction
`endif

    assign op       = opcode_t'(opcode);
    assign top_idx  = (depth != '0) ? IDX_W'(depth - DEPTH_W'(1)) : '0;
    assign sec_idx  = (depth >= DEPTH_W'(2)) ? IDX_W'(depth - DEPTH_W'(2)) : '0;
    assign push_idx = IDX_W'(depth);
    assign a_val    = stk[sec_idx];
    assign b_val    = stk[top_idx];

    assign ready = (state == ST_IDLE);
    assign disp  = entry_active ? entry : ((depth == '0) ? '0 : b_val);
    assign sign  = disp[WIDTH-1];

    assign entry_calc = ({4'b0, entry} * ENT_W'(DEC_BASE)) + ENT_W'(digit);

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .nrst    (nrst),
        .start   (mul_start),
        .a       (a_val),
        .b       (b_val),
        .done    (mul_done),
        .product (mul_product)
    );

    // The product fits only if its top WIDTH+1 bits are pure sign extension.
    assign mul_ovf = !((&mul_product[2*WIDTH-1:WIDTH-1]) || !(|mul_product[2*WIDTH-1:WIDTH-1]));
`ifdef CALC_SAT_EN
    assign mul_res = limit(mul_ovf, mul_product[2*WIDTH-1], mul_product[WIDTH-1:0]);
`else
    assign mul_res = mul_product[WIDTH-1:0];
`endif

    always_comb begin
        alu_wrap = '0;
        alu_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_wrap = a_val + b_val;
                alu_ovf  = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (alu_wrap[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_SUB: begin
                alu_wrap = a_val - b_val;
                alu_ovf  = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (alu_wrap[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_NEG: begin
                alu_wrap = '0 - b_val;
                alu_ovf  = (b_val == MIN_NEG);
            end
            default: ;
        endcase
`ifdef CALC_SAT_EN
        alu_res = limit(alu_ovf, (op == OP_NEG) ? 1'b0 : a_val[WIDTH-1], alu_wrap);
`else
        alu_res = alu_wrap;
`endif
    end

    // NOTE: every next-state signal gets its hold value first, so no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt        = state;
        stk_nxt          = stk;
        depth_nxt        = depth;
        entry_nxt        = entry;
        entry_active_nxt = entry_active;
        o_flag_nxt       = o_flag;
        err_nxt          = 1'b0;
        result_valid_nxt = 1'b0;
        mul_start        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            if (depth >= DEPTH_W'(2)) begin
                                stk_nxt[sec_idx] = alu_res;
                                depth_nxt        = depth - DEPTH_W'(1);
                                o_flag_nxt       = o_flag | alu_ovf;
                                result_valid_nxt = 1'b1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        OP_MUL: begin
                            if (depth >= DEPTH_W'(2)) begin
                                mul_start = 1'b1;
                                state_nxt = ST_MUL;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        OP_NEG: begin
                            if (depth != '0) begin
                                stk_nxt[top_idx] = alu_res;
                                o_flag_nxt       = o_flag | alu_ovf;
                                result_valid_nxt = 1'b1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        OP_DUP: begin
                            if (depth != '0 && depth < DEPTH_W'(DEPTH)) begin
                                stk_nxt[push_idx] = b_val;
                                depth_nxt         = depth + DEPTH_W'(1);
                                result_valid_nxt  = 1'b1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (depth >= DEPTH_W'(2)) begin
                                stk_nxt[top_idx] = a_val;
                                stk_nxt[sec_idx] = b_val;
                                result_valid_nxt = 1'b1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        OP_DROP: begin
                            if (depth != '0) begin
                                depth_nxt        = depth - DEPTH_W'(1);
                                result_valid_nxt = 1'b1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        OP_CLR: begin
                            for (int i = 0; i < DEPTH; i++) stk_nxt[i] = '0;
                            depth_nxt        = '0;
                            entry_nxt        = '0;
                            entry_active_nxt = 1'b0;
                            o_flag_nxt       = 1'b0;
                            result_valid_nxt = 1'b1;
                        end
                    endcase
                end else if (enter) begin
                    if (depth < DEPTH_W'(DEPTH)) begin
                        stk_nxt[push_idx] = entry;
                        depth_nxt         = depth + DEPTH_W'(1);
                        entry_nxt         = '0;
                        entry_active_nxt  = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (digit_valid && digit <= 4'd9) begin
                    if (entry_calc > ENTRY_MAX) begin
                        o_flag_nxt = 1'b1;
                        err_nxt    = 1'b1;
                    end else begin
                        entry_nxt        = entry_calc[WIDTH-1:0];
                        entry_active_nxt = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // Operands stay in place while busy, so sec_idx still names operand a.
                if (mul_done) begin
                    stk_nxt[sec_idx] = mul_res;
                    depth_nxt        = depth - DEPTH_W'(1);
                    o_flag_nxt       = o_flag | mul_ovf;
                    result_valid_nxt = 1'b1;
                    state_nxt        = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: the stack array is reset along with the control state so a fresh stack reads as zeros.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            depth        <= '0;
            entry        <= '0;
            entry_active <= 1'b0;
            o_flag       <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every register see the pre-edge values of the others.
            state        <= state_nxt;
            stk          <= stk_nxt;
            depth        <= depth_nxt;
            entry        <= entry_nxt;
            entry_active <= entry_active_nxt;
            o_flag       <= o_flag_nxt;
            err          <= err_nxt;
            result_valid <= result_valid_nxt;
        end
    end

endmodule
